// File: rtl/fetch_pc_predictor.sv
// Fetch PC generator with a bimodal (2-bit counter) conditional-branch predictor.
// Prediction is combinational on fetch_pc/instr; redirects land one cycle later; ena=0 stalls fetch.
module fetch_pc_predictor #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BHT_ENTRIES = 64,
  parameter int          IDX_W       = $clog2(BHT_ENTRIES),
  parameter logic [1:0]  INIT_CNT    = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ena,
  input  logic [31:0] instr,
  input  logic        redir_wr,
  input  logic [31:0] redir_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  output logic [31:0] fetch_pc,
  output logic        fetch_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic        is_branch;
    logic [31:0] bimm;
  } predec_t;

  predec_t          pd;
  logic [1:0]       cnt [BHT_ENTRIES];
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] uidx;
  logic [1:0]       upd_cur;
  logic [1:0]       upd_next;
  logic [31:0]      next_pc;
  logic             next_valid;

  // Bits outside the opcode/B-immediate fields and outside the table index are don't-care.
  logic unused_bits;
  assign unused_bits = ^{instr[24:12], upd_pc[31:IDX_W+2], upd_pc[1:0]};

  always_comb begin
    pd           = '0;
    pd.is_branch = (instr[6:0] == OP_BRANCH);
    pd.bimm      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  end

  assign idx         = fetch_pc[IDX_W+1:2];
  assign pred_taken  = pd.is_branch & cnt[idx][1];
  assign pred_target = fetch_pc + pd.bimm;

  // Saturating counter step for the retiring branch; lookup never sees this value the same cycle.
  assign uidx    = upd_pc[IDX_W+1:2];
  assign upd_cur = cnt[uidx];

  always_comb begin
    upd_next = upd_cur;
    if (upd_taken) begin
      if (upd_cur != 2'b11) upd_next = upd_cur + 2'b01;
    end else begin
      if (upd_cur != 2'b00) upd_next = upd_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) cnt[i] <= INIT_CNT;
    end else if (upd_valid) begin
      cnt[uidx] <= upd_next;
    end
  end

  // Redirect beats stall, stall beats prediction; a redirect always inserts one bubble.
  always_comb begin
    next_pc    = fetch_pc;
    next_valid = fetch_valid;
    if (redir_wr) begin
      next_pc    = redir_pc;
      next_valid = 1'b0;
    end else if (!ena) begin
      next_pc    = fetch_pc;
      next_valid = fetch_valid;
    end else if (pred_taken) begin
      next_pc    = pred_target;
      next_valid = 1'b1;
    end else begin
      next_pc    = fetch_pc + 32'd4;
      next_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      fetch_valid <= 1'b0;
    end else begin
      fetch_pc    <= next_pc;
      fetch_valid <= next_valid;
    end
  end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Directed bench for fetch_pc_predictor: stimulus queues expected outputs per cycle, a negedge monitor checks them.
module tb_fetch_pc_predictor;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] BEQ_P  = 32'h0200_0063; // beq +0x20
  localparam logic [31:0] BEQ_N  = 32'hFE00_00E3; // beq -0x20
  localparam logic [31:0] JAL_I  = 32'h0000_006F;
  localparam logic [31:0] JALR_I = 32'h0000_0067;

  logic        clk = 1'b0;
  logic        reset;
  logic        ena;
  logic [31:0] instr;
  logic        redir_wr;
  logic [31:0] redir_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        pred_taken;
  logic [31:0] pred_target;

  fetch_pc_predictor dut (
    .clk        (clk),
    .reset      (reset),
    .ena        (ena),
    .instr      (instr),
    .redir_wr   (redir_wr),
    .redir_pc   (redir_pc),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .fetch_pc   (fetch_pc),
    .fetch_valid(fetch_valid),
    .pred_taken (pred_taken),
    .pred_target(pred_target)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // mask bits: 0 fetch_pc, 1 fetch_valid, 2 pred_taken, 3 pred_target
  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] pc;
    logic        vld;
    logic        pt;
    logic [31:0] tgt;
    logic [3:0]  mask;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string n, input logic [31:0] pc, input logic vld,
                            input logic pt, input logic [31:0] tgt, input logic [3:0] m);
    exp_t e;
    e.cyc = cyc; e.name = n; e.pc = pc; e.vld = vld; e.pt = pt; e.tgt = tgt; e.mask = m;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      logic bad;
      e = exp_q.pop_front();
      tests++;
      bad = (e.cyc != cyc);
      if (e.mask[0] && fetch_pc    !== e.pc)  bad = 1'b1;
      if (e.mask[1] && fetch_valid !== e.vld) bad = 1'b1;
      if (e.mask[2] && pred_taken  !== e.pt)  bad = 1'b1;
      if (e.mask[3] && pred_target !== e.tgt) bad = 1'b1;
      if (bad) begin
        fails++;
        $display("FAIL %s cyc=%0d/%0d mask=%b got pc=%h vld=%b pt=%b tgt=%h want pc=%h vld=%b pt=%b tgt=%h",
                 e.name, cyc, e.cyc, e.mask, fetch_pc, fetch_valid, pred_taken, pred_target,
                 e.pc, e.vld, e.pt, e.tgt);
      end
    end
  end

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic t);
    upd_valid = v; upd_pc = pc; upd_taken = t;
  endtask

  initial begin
    reset = 1'b1; ena = 1'b0; instr = NOP; redir_wr = 1'b0; redir_pc = '0;
    set_upd(1'b0, 32'h0, 1'b0);

    step();                                             // c1
    expect_out("reset_state", 32'h0, 1'b0, 1'b0, 32'h0, 4'b0111);
    tests++;
    if (fetch_pc !== 32'h0 || fetch_valid !== 1'b0) begin
      fails++;
      $display("FAIL direct_reset_state got pc=%h vld=%b", fetch_pc, fetch_valid);
    end
    reset = 1'b0; ena = 1'b1;
    step();                                             // c2
    expect_out("first_fetch", 32'h4, 1'b1, 1'b0, 32'h0, 4'b0111);
    tests++;
    if (fetch_pc !== 32'h4) begin
      fails++;
      $display("FAIL direct_first_fetch_pc got pc=%h", fetch_pc);
    end
    tests++;
    if (fetch_valid !== 1'b1) begin
      fails++;
      $display("FAIL direct_first_fetch_vld got vld=%b", fetch_valid);
    end
    redir_wr = 1'b1; redir_pc = 32'h10;
    step();                                             // c3
    redir_wr = 1'b0; instr = BEQ_P;
    expect_out("beq_init_cnt", 32'h10, 1'b0, 1'b0, 32'h30, 4'b1111);
    step();                                             // c4
    instr = NOP;
    expect_out("not_taken_seq", 32'h14, 1'b1, 1'b0, 32'h0, 4'b0111);

    ena = 1'b0; set_upd(1'b1, 32'h10, 1'b1);
    step();                                             // c5 cnt=10
    expect_out("stall_hold", 32'h14, 1'b1, 1'b0, 32'h0, 4'b0011);
    step();                                             // c6 cnt=11
    set_upd(1'b0, 32'h0, 1'b0); redir_wr = 1'b1; redir_pc = 32'h10;
    step();                                             // c7
    redir_wr = 1'b0; ena = 1'b1; instr = BEQ_P;
    expect_out("beq_pred_taken", 32'h10, 1'b0, 1'b1, 32'h30, 4'b1111);
    step();                                             // c8
    instr = NOP;
    expect_out("taken_next_pc", 32'h30, 1'b1, 1'b0, 32'h0, 4'b0111);
    tests++;
    if (fetch_pc !== 32'h30) begin
      fails++;
      $display("FAIL direct_taken_next_pc got pc=%h", fetch_pc);
    end

    redir_wr = 1'b1; redir_pc = 32'h10;
    step();                                             // c9
    redir_wr = 1'b0; ena = 1'b0; instr = BEQ_P; set_upd(1'b1, 32'h10, 1'b1);
    expect_out("cnt11_taken", 32'h10, 1'b0, 1'b1, 32'h0, 4'b0101);
    step();                                             // c10 cnt stays 11
    upd_taken = 1'b0;
    expect_out("sat_high", 32'h0, 1'b0, 1'b1, 32'h0, 4'b0100);
    step();                                             // c11 cnt=10
    expect_out("dec_10_still_taken", 32'h0, 1'b0, 1'b1, 32'h0, 4'b0100);
    step();                                             // c12 cnt=01
    upd_taken = 1'b1;
    expect_out("dec_01_same_cycle_old", 32'h0, 1'b0, 1'b0, 32'h0, 4'b0100);
    step();                                             // c13 cnt=10
    upd_taken = 1'b0;
    expect_out("update_visible_next", 32'h0, 1'b0, 1'b1, 32'h0, 4'b0100);
    step(); step(); step();                             // c14..c16 cnt 01,00,00
    upd_taken = 1'b1;
    expect_out("sat_low", 32'h0, 1'b0, 1'b0, 32'h0, 4'b0100);
    step();                                             // c17 cnt=01
    expect_out("inc_from_00", 32'h0, 1'b0, 1'b0, 32'h0, 4'b0100);
    step();                                             // c18 cnt=10
    set_upd(1'b1, 32'h110, 1'b0);
    expect_out("inc_to_10", 32'h0, 1'b0, 1'b1, 32'h0, 4'b0100);

    step(); step();                                     // c19,c20 alias idx4 -> 00
    set_upd(1'b1, 32'h14, 1'b1);
    expect_out("alias_dec", 32'h10, 1'b0, 1'b0, 32'h0, 4'b0101);
    step();                                             // c21 idx5 only
    set_upd(1'b1, 32'h110, 1'b1);
    expect_out("other_idx_untouched", 32'h0, 1'b0, 1'b0, 32'h0, 4'b0100);
    step(); step();                                     // c22,c23 alias idx4 -> 10
    set_upd(1'b0, 32'h0, 1'b0);
    expect_out("alias_inc", 32'h0, 1'b0, 1'b1, 32'h0, 4'b0100);
    step();                                             // c24
    instr = JAL_I;
    expect_out("jal_no_pred", 32'h0, 1'b0, 1'b0, 32'h0, 4'b0100);
    step();                                             // c25
    instr = JALR_I;
    expect_out("jalr_no_pred", 32'h0, 1'b0, 1'b0, 32'h0, 4'b0100);
    step();                                             // c26
    instr = BEQ_N;
    expect_out("neg_target_wrap", 32'h10, 1'b0, 1'b1, 32'hFFFF_FFF0, 4'b1101);
    ena = 1'b1;
    step();                                             // c27
    instr = NOP;
    expect_out("neg_target_taken", 32'hFFFF_FFF0, 1'b1, 1'b0, 32'h0, 4'b0111);

    ena = 1'b0; redir_wr = 1'b1; redir_pc = 32'h200; set_upd(1'b1, 32'h10, 1'b0);
    step();                                             // c28 idx4 10->01
    redir_wr = 1'b0; ena = 1'b1; set_upd(1'b0, 32'h0, 1'b0);
    expect_out("redir_bubble", 32'h200, 1'b0, 1'b0, 32'h0, 4'b0011);
    tests++;
    if (fetch_pc !== 32'h200 || fetch_valid !== 1'b0) begin
      fails++;
      $display("FAIL direct_redir_bubble got pc=%h vld=%b", fetch_pc, fetch_valid);
    end
    step();                                             // c29
    expect_out("redir_resume", 32'h204, 1'b1, 1'b0, 32'h0, 4'b0011);
    redir_wr = 1'b1; redir_pc = 32'hFFFF_FFFC;
    step();                                             // c30
    redir_wr = 1'b0;
    expect_out("redir_high", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 4'b0011);
    step();                                             // c31
    expect_out("pc_wrap", 32'h0, 1'b1, 1'b0, 32'h0, 4'b0011);
    tests++;
    if (fetch_pc !== 32'h0) begin
      fails++;
      $display("FAIL direct_pc_wrap got pc=%h", fetch_pc);
    end
    redir_wr = 1'b1; redir_pc = 32'h10;
    step();                                             // c32
    redir_wr = 1'b0; ena = 1'b0; instr = BEQ_P;
    expect_out("redir_and_upd_both", 32'h10, 1'b0, 1'b0, 32'h0, 4'b0101);

    set_upd(1'b1, 32'h10, 1'b1);
    step(); step();                                     // c33,c34 cnt 10,11
    expect_out("pre_reset_taken", 32'h10, 1'b0, 1'b1, 32'h0, 4'b0101);
    step();                                             // c35 cnt 11, update still pending
    #2 reset = 1'b1;
    expect_out("async_reset", 32'h0, 1'b0, 1'b0, 32'h0, 4'b0111);
    step();                                             // c36
    reset = 1'b0; set_upd(1'b0, 32'h0, 1'b0); redir_wr = 1'b1; redir_pc = 32'h10;
    step();                                             // c37
    redir_wr = 1'b0;
    expect_out("cnt_init_after_reset", 32'h10, 1'b0, 1'b0, 32'h0, 4'b0111);
    set_upd(1'b1, 32'h10, 1'b1);
    step();                                             // c38 cnt=10
    set_upd(1'b0, 32'h0, 1'b0);
    expect_out("init_plus_one", 32'h10, 1'b0, 1'b1, 32'h0, 4'b0101);

    repeat (3) step();
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      fails++;
      $display("FAIL %s never checked (due cyc %0d, now %0d)", e.name, e.cyc, cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_pc_predictor.md
Name: fetch_pc_predictor

Overview:
- Fetch-side PC generator and dynamic branch predictor for the ERV24 pipeline.
- Holds the fetch PC and predecodes the fetched instruction. For conditional branches (opcode 1100011) it looks up a direct-mapped table of 2-bit saturating counters and steers fetch to pc+imm when the prediction is taken.
- Accepts redirects and resolution updates from the execute-stage jump controller.
- pred_taken travels down the pipeline as instruction flag bit 16.

Parameters:
- RESET_PC, 32'h00000000, fetch PC loaded on reset.
- BHT_ENTRIES, 64, number of counters; power of two, minimum 4.
- IDX_W, log2(BHT_ENTRIES), table index width; index = pc[IDX_W+1:2].
- INIT_CNT, 2'b01, counter value after reset (weakly not-taken).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ena  in  1  fetch advance enable; 0 = stall.
- instr  in  32  instruction at fetch_pc, valid in the same cycle (combinational imem read).
- redir_wr  in  1  redirect request (execute-stage pc_wr).
- redir_pc  in  32  redirect target (execute-stage pc_out).
- upd_valid  in  1  a resolved conditional branch is retiring this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual outcome (execute-stage branch_taken).
- fetch_pc  out  32  current fetch address (registered).
- fetch_valid  out  1  fetch_pc/instr pair is valid for decode.
- pred_taken  out  1  prediction for the instruction at fetch_pc (combinational).
- pred_target  out  32  fetch_pc + B-immediate (combinational; meaningful only when is_branch).

Behaviour:
- Reset (asynchronous, any cycle, including mid-update):
  - fetch_pc = RESET_PC, fetch_valid = 0.
  - All counters = INIT_CNT.
  - pred_taken follows combinationally from the reset state.
- Predecode:
  - is_branch = (instr[6:0] == 7'b1100011).
  - bimm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - pred_target = fetch_pc + bimm, mod 2^32, wraps silently.
- Lookup:
  - idx = fetch_pc[IDX_W+1:2].
  - pred_taken = is_branch && (cnt[idx][1] == 1).
  - Not asserted for JAL, JALR, or non-branch opcodes.
- Next-PC priority, evaluated each clock edge when not in reset:
  1. redir_wr: fetch_pc <= redir_pc; fetch_valid <= 0 for one cycle (bubble). Applies regardless of ena.
  2. !ena: fetch_pc and fetch_valid hold.
  3. pred_taken: fetch_pc <= pred_target; fetch_valid <= 1.
  4. Otherwise: fetch_pc <= fetch_pc + 4 (wraps 0xFFFFFFFC -> 0); fetch_valid <= 1.
- fetch_valid rises the first edge after reset deassertion with ena=1 and no redirect.
- Counter update:
  - On the edge with upd_valid=1, at uidx = upd_pc[IDX_W+1:2].
  - Taken: increment, saturating at 2'b11. Not taken: decrement, saturating at 2'b00.
  - Updates are independent of ena and redir_wr.
  - upd_pc low bits and high bits above the index are ignored; aliasing is accepted.
- Same-cycle update and lookup on the same index:
  - Lookup uses the pre-update value (no bypass).
  - The new value is visible from the next cycle.
- Redirect and update in the same cycle: both take effect.
- Latency:
  - Prediction is zero-cycle combinational on fetch_pc/instr.
  - The redirected PC appears on fetch_pc one cycle after redir_wr.
- No X propagation: on an unrecognised opcode, pred_taken = 0.

Test Plan:
- Reset with RESET_PC=0: fetch_pc=0x0, fetch_valid=0, pred_taken=0. Release reset with ena=1 and instr=NOP -> fetch_pc=0x4, fetch_valid=1.
- At fetch_pc=0x10, instr = beq with offset +0x20 (0x02000063), counter at init 01 -> pred_taken=0, pred_target=0x30, next fetch_pc=0x14.
- Two updates (upd_pc=0x10, upd_taken=1), then fetch 0x10 with the same beq -> pred_taken=1, next fetch_pc=0x30.
- Saturation: 3 taken updates at 0x10 -> counter 11. One not-taken update -> 10, still predicts taken. A second not-taken -> 01, pred_taken=0.
- Redirect priority: ena=0, redir_wr=1, redir_pc=0x200 -> next fetch_pc=0x200, fetch_valid=0 for one cycle, then 1.
- Aliasing, same-cycle update, and async reset:
  - Taken updates at 0x110 change the prediction for 0x10 (shared idx 4, BHT_ENTRIES=64).
  - An update and a lookup on idx 4 in the same cycle -> pred_taken reflects the old counter.
  - Async reset asserted mid-cycle -> fetch_pc=0 immediately and counters return to 01.
